da_sched: RTL and testbench
===========================

// Module: da_sched
// PURPOSE
//  Sequencer for the 8-block distributed-arithmetic FIR datapath. It runs in two phases.
//  LOAD: streams the coefficient tables into the SRAM bank (CLOAD/CADDR/CIN).
//  RUN: keeps the 64-tap sample delay line and issues SAMP_W bit-planes per sample, MSB first,
//  as eight 8-bit ROM addresses. It then captures the accumulator into a 1-deep result buffer.
//  It sits between the sample/config sources and the DA datapath (A7..A0, valid_in, start, ACC_OUT).
// PARAMETERS
//  SAMP_W     16  input sample width = bit-planes per output sample
//  COEF_W     20  coefficient table word width (CIN)
//  ACC_W      38  accumulator/result width
//  CADDR_W    11  table address width; 2**CADDR_W words are loaded (8 blocks x 256)
//  OFFSET_BIN 1   1: invert the sample MSB when forming addresses (tables are built for offset-binary)
// PORTS
//  clk        in   1        clock, rising edge
//  resetn     in   1        asynchronous active-low reset
//  cfg_start  in   1        pulse: begin a table load (honoured in IDLE/READY only)
//  cfg_data   in   COEF_W   table word
//  cfg_valid  in   1        cfg_data valid
//  cfg_ready  out  1        table word accepted when cfg_valid&cfg_ready
//  loaded     out  1        set when a full table load completes; cleared by reset/cfg_start
//  x_data     in   SAMP_W   new input sample, two's complement
//  x_valid    in   1        sample valid
//  x_ready    out  1        sample accepted when x_valid&x_ready
//  CLOAD      out  1        to datapath: table-load mode
//  CADDR      out  CADDR_W  to datapath: table write address
//  CIN        out  COEF_W   to datapath: table write data
//  A7..A0     out  8 each   to datapath: ROM addresses for the current bit-plane
//  start      out  1        to datapath: 1-cycle pulse with the first (MSB) plane of a sample
//  valid_in   out  1        to datapath: 1-cycle pulse, plane addresses valid
//  plane_done in   1        from datapath: plane absorbed, ACC_OUT updated
//  ACC_OUT    in   ACC_W    from datapath: accumulator
//  y_data     out  ACC_W    filter output
//  y_valid    out  1        y_data valid; held until y_ready
//  y_ready    in   1        consumer accepts y_data
// BEHAVIOUR
//  Reset (async): state=IDLE. All outputs, taps, counters and y_data are 0. loaded=0.
//  States: IDLE, LOAD, READY, ISSUE, WAIT.
//  IDLE: x_ready=0. cfg_start -> LOAD.
//  LOAD: CLOAD=1, cfg_ready=1.
//   - Each accepted word drives CIN=cfg_data, CADDR=cnt in the same cycle; cnt++.
//   - On the word with cnt=2**CADDR_W-1: state -> READY, loaded=1, CLOAD=0 the next cycle.
//   - cnt wraps to 0. cfg_valid gaps are allowed; no timeout.
//  READY: x_ready = ~y_valid | y_ready.
//   - On accept: tap[63:1]<=tap[62:0], tap[0]<=x_data, b<=SAMP_W-1, state -> ISSUE.
//   - cfg_start takes priority over x_valid in the same cycle: -> LOAD, loaded=0.
//  ISSUE: one cycle. Drives A_k[j] = tap[8k+j][b] (k=0..7, j=0..7).
//   - When OFFSET_BIN=1 and b==SAMP_W-1, each bit is inverted.
//   - valid_in=1; start=1 only when b==SAMP_W-1. -> WAIT.
//  WAIT: A7..A0 held stable; valid_in=0. Waits any number of cycles for plane_done.
//   - plane_done with b>0: b--, -> ISSUE.
//   - plane_done with b==0: y_data<=ACC_OUT, y_valid<=1, -> READY.
//   - plane_done outside WAIT is ignored.
//  Output buffer:
//   - y_valid clears on y_ready unless a new capture happens in the same cycle (new data wins).
//   - A new capture can never overwrite unaccepted data, because x_ready gates the sample.
//  cfg_start during ISSUE/WAIT/LOAD is ignored (no queueing).
//  Latency: x accept -> y_valid = SAMP_W*(1+L)+1 cycles, where L = cycles valid_in->plane_done (L>=1).
//  Arithmetic: no arithmetic beyond counters. b is clog2(SAMP_W) bits. cnt is CADDR_W bits.
//  Reset mid-operation: state aborts to IDLE, loaded=0. Taps are cleared and RUN requires a full reload.
// TESTING
//  T1 load: cfg_start, 2048 words data=addr -> CADDR 0..2047 with matching CIN, CLOAD 1 for exactly those cycles, loaded=1 after.
//  T2 plane order: load done, tap[0..63]=0; x_data=16'h8001 -> A0[0] pattern MSB plane (inverted)=0, planes 14..1=0, plane 0 A0=8'h01; start once, valid_in 16 times.
//  T3 backpressure: y_ready=0 after first result -> x_ready=0, second sample stalls until y_ready=1, y_data of first unchanged.
//  T4 plane_done delay: datapath model L=1 then L=5 -> y_valid at 33 and 97 cycles after accept, A buses stable throughout WAIT.
//  T5 priority: cfg_start and x_valid same cycle in READY -> LOAD entered, sample not accepted, loaded=0.
//  T6 reset mid-WAIT at plane 7 -> all outputs 0 immediately, x_ready=0 until full reload.

Source files
------------

// File: rtl/da_sched_if.sv
// Bus bundle between da_sched, its config/sample sources, the result consumer and the DA datapath.
interface da_sched_if #(
    parameter int unsigned SAMP_W  = 16,
    parameter int unsigned COEF_W  = 20,
    parameter int unsigned ACC_W   = 38,
    parameter int unsigned CADDR_W = 11
);
    // Table-load side
    logic               cfg_start;
    logic [COEF_W-1:0]  cfg_data;
    logic               cfg_valid;
    logic               cfg_ready;
    logic               loaded;
    // Sample input
    logic [SAMP_W-1:0]  x_data;
    logic               x_valid;
    logic               x_ready;
    // Datapath side
    logic               CLOAD;
    logic [CADDR_W-1:0] CADDR;
    logic [COEF_W-1:0]  CIN;
    logic [7:0]         A7, A6, A5, A4, A3, A2, A1, A0;
    logic               start;
    logic               valid_in;
    logic               plane_done;
    logic [ACC_W-1:0]   ACC_OUT;
    // Result output
    logic [ACC_W-1:0]   y_data;
    logic               y_valid;
    logic               y_ready;

    // Scheduler view
    modport slave (
        input  cfg_start, cfg_data, cfg_valid, x_data, x_valid, plane_done, ACC_OUT, y_ready,
        output cfg_ready, loaded, x_ready, CLOAD, CADDR, CIN,
               A7, A6, A5, A4, A3, A2, A1, A0, start, valid_in, y_data, y_valid
    );

    // Environment view (sources, datapath, consumer)
    modport master (
        output cfg_start, cfg_data, cfg_valid, x_data, x_valid, plane_done, ACC_OUT, y_ready,
        input  cfg_ready, loaded, x_ready, CLOAD, CADDR, CIN,
               A7, A6, A5, A4, A3, A2, A1, A0, start, valid_in, y_data, y_valid
    );
endinterface

// File: rtl/da_sched.sv
// Sequencer for the 8-block distributed-arithmetic FIR: table load, 64-tap delay line,
// MSB-first bit-plane address issue and a 1-deep result buffer.
module da_sched #(
    parameter int unsigned SAMP_W     = 16,
    parameter int unsigned COEF_W     = 20,
    parameter int unsigned ACC_W      = 38,
    parameter int unsigned CADDR_W    = 11,
    parameter bit          OFFSET_BIN = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    da_sched_if.slave   bus
);
    localparam int unsigned TAPS = 64;
    localparam int unsigned B_W  = (SAMP_W > 1) ? $clog2(SAMP_W) : 1;
    localparam logic [B_W-1:0] B_MSB = B_W'(SAMP_W - 1);

    typedef enum logic [2:0] {IDLE, LOAD, READY, ISSUE, WAIT} state_t;

    state_t                        state_q, state_d;
    logic [CADDR_W-1:0]            cnt_q, cnt_d;
    logic [B_W-1:0]                b_q, b_d;
    logic [TAPS-1:0][SAMP_W-1:0]   tap_q, tap_d;
    logic [7:0][7:0]               a_q, a_d;
    logic                          valid_in_q, valid_in_d;
    logic                          start_q, start_d;
    logic                          cload_q, cload_d;
    logic                          loaded_q, loaded_d;
    logic [ACC_W-1:0]              y_data_q, y_data_d;
    logic                          y_valid_q, y_valid_d;
    logic                          x_ready_c;
    logic                          issue_c;

    // A sample is taken only in READY, never alongside cfg_start, and only if the buffer will be free
    assign x_ready_c = (state_q == READY) && !bus.cfg_start && (!y_valid_q || bus.y_ready);

    // Next-state, counter, delay-line and plane-address logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        b_d        = b_q;
        tap_d      = tap_q;
        a_d        = a_q;
        valid_in_d = 1'b0;
        start_d    = 1'b0;
        cload_d    = cload_q;
        loaded_d   = loaded_q;
        y_data_d   = y_data_q;
        y_valid_d  = y_valid_q;
        issue_c    = 1'b0;

        if (y_valid_q && bus.y_ready) begin
            y_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.cfg_start) begin
                    state_d = LOAD;
                    cload_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (bus.cfg_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == {CADDR_W{1'b1}}) begin
                        state_d  = READY;
                        cload_d  = 1'b0;
                        loaded_d = 1'b1;
                    end
                end
            end
            READY: begin
                if (bus.cfg_start) begin
                    state_d  = LOAD;
                    cload_d  = 1'b1;
                    loaded_d = 1'b0;
                    cnt_d    = '0;
                end else if (bus.x_valid && x_ready_c) begin
                    tap_d   = {tap_q[TAPS-2:0], bus.x_data};
                    b_d     = B_MSB;
                    state_d = ISSUE;
                    issue_c = 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.plane_done) begin
                    if (b_q != '0) begin
                        b_d     = b_q - 1'b1;
                        state_d = ISSUE;
                        issue_c = 1'b1;
                    end else begin
                        y_data_d  = bus.ACC_OUT;
                        y_valid_d = 1'b1;
                        state_d   = READY;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Addresses are registered on entry to ISSUE so they appear together with valid_in
        if (issue_c) begin
            valid_in_d = 1'b1;
            start_d    = (b_d == B_MSB);
            for (int k = 0; k < 8; k++) begin
                for (int j = 0; j < 8; j++) begin
                    a_d[k][j] = tap_d[8*k+j][b_d] ^ (OFFSET_BIN && (b_d == B_MSB));
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            b_q        <= '0;
            tap_q      <= '0;
            a_q        <= '0;
            valid_in_q <= 1'b0;
            start_q    <= 1'b0;
            cload_q    <= 1'b0;
            loaded_q   <= 1'b0;
            y_data_q   <= '0;
            y_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            b_q        <= b_d;
            tap_q      <= tap_d;
            a_q        <= a_d;
            valid_in_q <= valid_in_d;
            start_q    <= start_d;
            cload_q    <= cload_d;
            loaded_q   <= loaded_d;
            y_data_q   <= y_data_d;
            y_valid_q  <= y_valid_d;
        end
    end

    // Table write data follows the source word while loading, zero otherwise
    assign bus.CLOAD     = cload_q;
    assign bus.cfg_ready = cload_q;
    assign bus.CADDR     = cnt_q;
    assign bus.CIN       = cload_q ? bus.cfg_data : '0;
    assign bus.loaded    = loaded_q;
    assign bus.x_ready   = x_ready_c;
    assign bus.A0        = a_q[0];
    assign bus.A1        = a_q[1];
    assign bus.A2        = a_q[2];
    assign bus.A3        = a_q[3];
    assign bus.A4        = a_q[4];
    assign bus.A5        = a_q[5];
    assign bus.A6        = a_q[6];
    assign bus.A7        = a_q[7];
    assign bus.start     = start_q;
    assign bus.valid_in  = valid_in_q;
    assign bus.y_data    = y_data_q;
    assign bus.y_valid   = y_valid_q;
endmodule

// File: tb/tb_da_sched.sv
// Directed bench for da_sched with a small datapath model (plane_done after L cycles, ACC_OUT counts planes).
module tb_da_sched;
    localparam int unsigned SAMP_W  = 16;
    localparam int unsigned COEF_W  = 20;
    localparam int unsigned ACC_W   = 38;
    localparam int unsigned CADDR_W = 11;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    da_sched_if #(.SAMP_W(SAMP_W), .COEF_W(COEF_W), .ACC_W(ACC_W), .CADDR_W(CADDR_W)) bus ();

    da_sched #(.SAMP_W(SAMP_W), .COEF_W(COEF_W), .ACC_W(ACC_W), .CADDR_W(CADDR_W), .OFFSET_BIN(1'b1)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int L = 1;

    // Per-sample observations filled by run_sample
    int          lat, vins, starts, unstable;
    logic        yv_at1;
    logic [7:0]  a0s [16];
    logic [7:0]  a1s [16];
    logic [7:0]  a7s [16];
    logic [ACC_W-1:0] acc_before;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Datapath model: plane_done in the L-th cycle after each valid_in, ACC_OUT bumped per plane
    initial begin
        bus.plane_done = 1'b0;
        bus.ACC_OUT    = '0;
        forever begin
            @(posedge clk); #1;
            while (bus.valid_in === 1'b1) begin
                repeat (L) @(posedge clk);
                #1;
                bus.plane_done = 1'b1;
                bus.ACC_OUT    = bus.ACC_OUT + 38'd1;
                @(posedge clk); #1;
                bus.plane_done = 1'b0;
            end
        end
    end

    // Full table load; optional cfg_valid gaps and an ignored cfg_start mid-load
    task automatic do_load(input bit pulse, input bit gap, input bit poke, input logic [COEF_W-1:0] mask);
        int bad = 0;
        if (pulse) begin
            bus.cfg_start = 1'b1;
            @(posedge clk); #1;
            bus.cfg_start = 1'b0;
        end
        for (int i = 0; i < (1 << CADDR_W); i++) begin
            if (gap && (i % 7) == 3) begin
                bus.cfg_valid = 1'b0;
                #1;
                if (bus.CLOAD !== 1'b1 || bus.CADDR !== CADDR_W'(i)) bad++;
                @(posedge clk); #1;
            end
            bus.cfg_data  = COEF_W'(i) ^ mask;
            bus.cfg_valid = 1'b1;
            if (poke && i == 100) bus.cfg_start = 1'b1;
            #1;
            if (bus.CLOAD !== 1'b1 || bus.cfg_ready !== 1'b1 || bus.CADDR !== CADDR_W'(i) ||
                bus.CIN !== (COEF_W'(i) ^ mask)) bad++;
            @(posedge clk); #1;
            bus.cfg_start = 1'b0;
        end
        bus.cfg_valid = 1'b0;
        #1;
        check("load_words", 64'(bad), 64'(0));
        check("load_cload_off", 64'(bus.CLOAD), 64'(0));
        check("load_loaded", 64'(bus.loaded), 64'(1));
        check("load_cfg_ready_off", 64'(bus.cfg_ready), 64'(0));
    endtask

    // Offer one sample, then log planes until y_valid; lat counts the accept cycle as cycle 0
    task automatic run_sample(input logic [SAMP_W-1:0] xd);
        logic [63:0] snap, cur;
        int t, idx;
        vins = 0; starts = 0; unstable = 0; lat = 0; yv_at1 = 1'bx; snap = '0;
        for (int i = 0; i < 16; i++) begin a0s[i] = 'x; a1s[i] = 'x; a7s[i] = 'x; end
        acc_before  = bus.ACC_OUT;
        bus.x_data  = xd;
        bus.x_valid = 1'b1;
        #1;
        t = 0;
        while (bus.x_ready !== 1'b1 && t < 200) begin @(posedge clk); #1; t++; end
        check("sample_accept", 64'(bus.x_ready), 64'(1));
        if (bus.x_ready === 1'b1) begin
            @(posedge clk); #1;
            bus.x_valid = 1'b0;
            lat = 1;
            yv_at1 = bus.y_valid;
            t = 0;
            while (bus.y_valid !== 1'b1 && t < 1000) begin
                cur = {bus.A7, bus.A6, bus.A5, bus.A4, bus.A3, bus.A2, bus.A1, bus.A0};
                if (bus.valid_in === 1'b1) begin
                    idx = 15 - vins;
                    if (idx >= 0) begin a0s[idx] = bus.A0; a1s[idx] = bus.A1; a7s[idx] = bus.A7; end
                    if (bus.start === 1'b1) starts++;
                    vins++;
                    snap = cur;
                end else if (vins > 0 && cur !== snap) begin
                    unstable++;
                end
                @(posedge clk); #1;
                lat++; t++;
            end
            check("sample_y_valid", 64'(bus.y_valid), 64'(1));
        end
    endtask

    initial begin
        int bad;
        logic [ACC_W-1:0] y_first;

        resetn = 1'b0;
        bus.cfg_start = 1'b0; bus.cfg_data = '0; bus.cfg_valid = 1'b0;
        bus.x_data = '0; bus.x_valid = 1'b0; bus.y_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", 64'({bus.CLOAD, bus.cfg_ready, bus.loaded, bus.x_ready, bus.start, bus.valid_in, bus.y_valid}), 64'(0));
        check("rst_addr", {bus.A7, bus.A6, bus.A5, bus.A4, bus.A3, bus.A2, bus.A1, bus.A0}, 64'(0));
        check("rst_y_data", 64'(bus.y_data), 64'(0));
        resetn = 1'b1;
        bus.x_valid = 1'b1;
        @(posedge clk); #1;
        check("idle_x_ready", 64'(bus.x_ready), 64'(0));
        bus.x_valid = 1'b0;

        // T1: continuous load, data = address
        do_load(1'b1, 1'b0, 1'b0, '0);

        // T2: plane order, MSB plane inverted, result held with y_ready low
        L = 1;
        bus.y_ready = 1'b0;
        run_sample(16'h8001);
        y_first = acc_before + 38'd16;
        check("t2_latency", 64'(lat), 64'(33));
        check("t2_valid_in_cnt", 64'(vins), 64'(16));
        check("t2_start_cnt", 64'(starts), 64'(1));
        check("t2_a0_msb", 64'(a0s[15]), 64'(8'hFE));
        check("t2_a7_msb", 64'(a7s[15]), 64'(8'hFF));
        bad = 0;
        for (int p = 1; p <= 14; p++) if (a0s[p] !== 8'h00 || a7s[p] !== 8'h00) bad++;
        check("t2_mid_planes_zero", 64'(bad), 64'(0));
        check("t2_a0_lsb", 64'(a0s[0]), 64'(8'h01));
        check("t2_a_stable", 64'(unstable), 64'(0));
        check("t2_y_data", 64'(bus.y_data), 64'(y_first));

        // T3: backpressure stalls the next sample and holds y_data
        bus.x_data  = 16'h4000;
        bus.x_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("t3_x_ready_low", 64'(bus.x_ready), 64'(0));
            check("t3_y_valid_held", 64'(bus.y_valid), 64'(1));
            check("t3_y_data_held", 64'(bus.y_data), 64'(y_first));
            check("t3_no_issue", 64'(bus.valid_in), 64'(0));
        end

        // T4: release, second sample with L=5
        bus.y_ready = 1'b1;
        L = 5;
        run_sample(16'h4000);
        check("t4_y_valid_cleared_on_accept", 64'(yv_at1), 64'(0));
        check("t4_latency", 64'(lat), 64'(97));
        check("t4_valid_in_cnt", 64'(vins), 64'(16));
        check("t4_a_stable", 64'(unstable), 64'(0));
        check("t4_a0_msb", 64'(a0s[15]), 64'(8'hFD));
        check("t4_a1_msb", 64'(a1s[15]), 64'(8'hFF));
        check("t4_a0_b14", 64'(a0s[14]), 64'(8'h01));
        check("t4_a0_lsb", 64'(a0s[0]), 64'(8'h02));
        check("t4_y_data", 64'(bus.y_data), 64'(acc_before + 38'd16));

        // T5: cfg_start beats x_valid in READY; reload with gaps and an ignored cfg_start
        bus.cfg_start = 1'b1;
        bus.x_data    = 16'h1234;
        bus.x_valid   = 1'b1;
        #1;
        check("t5_x_ready_gated", 64'(bus.x_ready), 64'(0));
        @(posedge clk); #1;
        bus.cfg_start = 1'b0;
        bus.x_valid   = 1'b0;
        check("t5_cload", 64'(bus.CLOAD), 64'(1));
        check("t5_loaded_clr", 64'(bus.loaded), 64'(0));
        check("t5_no_issue", 64'(bus.valid_in), 64'(0));
        check("t5_y_valid_clr", 64'(bus.y_valid), 64'(0));
        do_load(1'b0, 1'b1, 1'b1, 20'hA5A5A);

        // Delay line: taps are 4000 and 8001 from before
        L = 1;
        run_sample(16'hFFFF);
        check("t5_latency", 64'(lat), 64'(33));
        check("t5_a0_msb", 64'(a0s[15]), 64'(8'hFA));
        check("t5_a0_b14", 64'(a0s[14]), 64'(8'h03));
        check("t5_a0_b1", 64'(a0s[1]), 64'(8'h01));
        check("t5_a0_lsb", 64'(a0s[0]), 64'(8'h05));
        // Push eight zeros so FFFF/4000/8001 land on taps 8..10 (block 1)
        for (int s = 0; s < 8; s++) run_sample(16'h0000);
        check("tap_a0_msb", 64'(a0s[15]), 64'(8'hFF));
        check("tap_a1_msb", 64'(a1s[15]), 64'(8'hFA));
        check("tap_a1_b14", 64'(a1s[14]), 64'(8'h03));
        check("tap_a1_lsb", 64'(a1s[0]), 64'(8'h05));
        check("tap_a0_lsb", 64'(a0s[0]), 64'(8'h00));
        check("tap_y_data", 64'(bus.y_data), 64'(acc_before + 38'd16));

        // T6: reset while waiting on plane 7
        L = 5;
        bus.cfg_data = 20'hABCDE;
        bus.x_data   = 16'h0001;
        bus.x_valid  = 1'b1;
        #1;
        check("t6_accept", 64'(bus.x_ready), 64'(1));
        @(posedge clk); #1;
        bus.x_valid = 1'b0;
        vins = 0;
        for (int t = 0; t < 500 && vins < 9; t++) begin
            if (bus.valid_in === 1'b1) vins++;
            if (vins < 9) begin @(posedge clk); #1; end
        end
        check("t6_reached_plane7", 64'(vins), 64'(9));
        @(posedge clk); #1;
        check("t6_in_wait", 64'(bus.valid_in), 64'(0));
        #2;
        resetn = 1'b0;
        #1;
        check("t6_rst_ctrl", 64'({bus.CLOAD, bus.cfg_ready, bus.loaded, bus.x_ready, bus.start, bus.valid_in, bus.y_valid}), 64'(0));
        check("t6_rst_addr", {bus.A7, bus.A6, bus.A5, bus.A4, bus.A3, bus.A2, bus.A1, bus.A0}, 64'(0));
        check("t6_rst_caddr_cin", 64'({bus.CADDR, bus.CIN}), 64'(0));
        check("t6_rst_y_data", 64'(bus.y_data), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        bus.x_valid = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus.x_ready !== 1'b0 || bus.valid_in !== 1'b0 || bus.loaded !== 1'b0) bad++;
        end
        check("t6_blocked_until_reload", 64'(bad), 64'(0));
        bus.x_valid = 1'b0;
        do_load(1'b1, 1'b0, 1'b0, '0);
        check("t6_x_ready_after_load", 64'(bus.x_ready), 64'(1));
        L = 1;
        run_sample(16'h0000);
        check("t6_latency", 64'(lat), 64'(33));
        check("t6_taps_cleared_msb", 64'({a1s[15], a0s[15]}), 64'(16'hFFFF));
        check("t6_taps_cleared_lsb", 64'({a1s[0], a0s[0]}), 64'(16'h0000));

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
